// File: rtl/call_ctrl_pkg.sv
// Shared types and constants for the call/return controller.
package call_ctrl_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    FAULT = 1'b1
  } state_t;

  // Program counter target driven while the controller sits in FAULT.
  localparam int unsigned FAULT_VEC = 0;

endpackage

// File: rtl/call_ctrl_ret_stack.sv
// ret_stack: return-address LIFO built on a ring buffer; CIRCULAR=1 lets a push
// at full depth overwrite the oldest entry while the depth count saturates.
module ret_stack #(
  parameter int unsigned ADDR_W   = 5,
  parameter int unsigned DEPTH    = 4,
  parameter bit          CIRCULAR = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  input  logic [ADDR_W-1:0]          push_data,
  output logic [ADDR_W-1:0]          top,
  output logic [$clog2(DEPTH):0]     depth
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned DW = PW + 1;
  localparam logic [DW-1:0] FULL = DW'(DEPTH);

  logic [ADDR_W-1:0] mem [DEPTH];
  logic [PW-1:0]     ptr;
  logic [DW-1:0]     count;

  // ptr always names the top entry; the slot after it is the oldest once full,
  // so advancing the pointer on a full push is exactly a circular overwrite.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr   <= '0;
      count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (push) begin
      if (count != FULL || CIRCULAR) begin
        ptr                <= ptr + PW'(1);
        mem[ptr + PW'(1)]  <= push_data;
        if (count != FULL) count <= count + DW'(1);
      end
    end else if (pop && count != '0) begin
      ptr   <= ptr - PW'(1);
      count <= count - DW'(1);
    end
  end

  assign top   = (count != '0) ? mem[ptr] : '0;
  assign depth = count;

endmodule

// File: rtl/call_ctrl.sv
// Call/branch/return controller with a return-address stack.
// Define CALL_CTRL_GUARD_EN to trap stack overflow/underflow into a FAULT state.
module call_ctrl
  import call_ctrl_pkg::*;
#(
  parameter int unsigned INSTR_ADDR_SIZE = 5,
  parameter int unsigned STACK_DEPTH     = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           call,
  input  logic                           branch,
  input  logic                           rtn,
  input  logic [INSTR_ADDR_SIZE-1:0]     tgt_addr,
  input  logic [INSTR_ADDR_SIZE-1:0]     instr_addr,
  input  logic                           fault_clr,
  output logic                           jmp,
  output logic [INSTR_ADDR_SIZE-1:0]     jmp_addr,
  output logic                           ret,
  output logic [INSTR_ADDR_SIZE-1:0]     ret_addr,
  output logic [$clog2(STACK_DEPTH):0]   depth,
  output logic                           fault
);

  localparam int unsigned DW = $clog2(STACK_DEPTH) + 1;
  localparam logic [DW-1:0] FULL = DW'(STACK_DEPTH);

  logic                       running;
  logic                       acc_call;
  logic                       acc_branch;
  logic                       acc_rtn;
  logic                       push;
  logic                       pop;
  logic                       clear;
  logic [INSTR_ADDR_SIZE-1:0] top;

  assign acc_call   = running && call;
  assign acc_branch = running && !call && branch;
  assign acc_rtn    = running && !call && !branch && rtn;

`ifdef CALL_CTRL_GUARD_EN
  state_t state;
  state_t next_state;
  logic   overflow;
  logic   underflow;

  assign overflow  = acc_call && (depth == FULL);
  assign underflow = acc_rtn && (depth == '0);
  assign running   = (state == RUN);
  assign push      = acc_call && !overflow;
  assign pop       = acc_rtn && !underflow;
  assign clear     = (state == FAULT) && fault_clr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      RUN:     if (overflow || underflow) next_state = FAULT;
      FAULT:   if (fault_clr) next_state = RUN;
      default: next_state = RUN;
    endcase
  end

  always_comb begin
    jmp      = 1'b0;
    jmp_addr = '0;
    ret      = 1'b0;
    fault    = 1'b0;
    if (!rst) begin
      if (state == FAULT) begin
        jmp      = 1'b1;
        jmp_addr = INSTR_ADDR_SIZE'(FAULT_VEC);
        fault    = 1'b1;
      end else begin
        jmp      = push || acc_branch;
        jmp_addr = (push || acc_branch) ? tgt_addr : '0;
        ret      = pop;
      end
    end
  end
`else
  logic unused_fault_clr;

  assign unused_fault_clr = fault_clr;
  assign running          = 1'b1;
  assign push             = acc_call;
  assign pop              = acc_rtn;
  assign clear            = 1'b0;

  always_comb begin
    jmp      = 1'b0;
    jmp_addr = '0;
    ret      = 1'b0;
    fault    = 1'b0;
    if (!rst) begin
      jmp      = acc_call || acc_branch;
      jmp_addr = (acc_call || acc_branch) ? tgt_addr : '0;
      ret      = acc_rtn;
    end
  end
`endif

  assign ret_addr = rst ? '0 : top;

  ret_stack #(
    .ADDR_W   (INSTR_ADDR_SIZE),
`ifdef CALL_CTRL_GUARD_EN
    .CIRCULAR (1'b0),
`else
    .CIRCULAR (1'b1),
`endif
    .DEPTH    (STACK_DEPTH)
  ) u_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .pop       (pop),
    .clear     (clear),
    .push_data (instr_addr + INSTR_ADDR_SIZE'(1)),
    .top       (top),
    .depth     (depth)
  );

endmodule

// File: tb/tb_call_ctrl.sv
// Directed self-checking bench for call_ctrl (default parameters); guarded
// overflow/underflow checks build when CALL_CTRL_GUARD_EN is defined.
module tb_call_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       call, branch, rtn, fault_clr;
  logic [4:0] tgt_addr, instr_addr;
  logic       jmp, ret, fault;
  logic [4:0] jmp_addr, ret_addr;
  logic [2:0] depth;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  call_ctrl #(
    .INSTR_ADDR_SIZE (5),
    .STACK_DEPTH     (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .call       (call),
    .branch     (branch),
    .rtn        (rtn),
    .tgt_addr   (tgt_addr),
    .instr_addr (instr_addr),
    .fault_clr  (fault_clr),
    .jmp        (jmp),
    .jmp_addr   (jmp_addr),
    .ret        (ret),
    .ret_addr   (ret_addr),
    .depth      (depth),
    .fault      (fault)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Apply a request at the negedge and let combinational outputs settle.
  task automatic drive(input logic c, input logic b, input logic r,
                       input logic [4:0] tgt, input logic [4:0] ia, input logic fc);
    @(negedge clk);
    call = c; branch = b; rtn = r; tgt_addr = tgt; instr_addr = ia; fault_clr = fc;
    #1;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    call = 0; branch = 0; rtn = 0; fault_clr = 0; tgt_addr = 0; instr_addr = 0;
    #3;
    check_eq("rst_depth", depth, 0);
    check_eq("rst_jmp", jmp, 0);
    check_eq("rst_ret_addr", ret_addr, 0);
    check_eq("rst_fault", fault, 0);
    @(negedge clk); rst = 1'b0;

    // call at 5 -> 20
    drive(1, 0, 0, 20, 5, 0);
    check_eq("call_jmp", jmp, 1);
    check_eq("call_jmp_addr", jmp_addr, 20);
    check_eq("call_ret", ret, 0);
    tick;
    check_eq("call_depth", depth, 1);
    check_eq("call_top", ret_addr, 6);

    drive(0, 0, 0, 17, 0, 0);
    check_eq("idle_jmp", jmp, 0);
    check_eq("idle_jmp_addr", jmp_addr, 0);

    drive(0, 1, 0, 12, 8, 0);
    check_eq("br_jmp", jmp, 1);
    check_eq("br_jmp_addr", jmp_addr, 12);
    tick;
    check_eq("br_depth", depth, 1);

    drive(0, 0, 1, 0, 21, 0);
    check_eq("rtn_ret", ret, 1);
    check_eq("rtn_ret_addr", ret_addr, 6);
    check_eq("rtn_jmp", jmp, 0);
    tick;
    check_eq("rtn_depth", depth, 0);
    check_eq("rtn_empty_top", ret_addr, 0);

    // priority: call wins, no pop
    drive(1, 1, 1, 9, 10, 0);
    check_eq("pri_jmp_addr", jmp_addr, 9);
    check_eq("pri_ret", ret, 0);
    tick;
    check_eq("pri_depth", depth, 1);
    check_eq("pri_top", ret_addr, 11);

    // wrap of instr_addr+1
    drive(1, 0, 0, 3, 31, 0);
    tick;
    check_eq("wrap_depth", depth, 2);
    check_eq("wrap_top", ret_addr, 0);

    drive(1, 0, 0, 4, 7, 0);
    tick;
    check_eq("pre_rst_depth", depth, 3);

    // asynchronous reset mid-request
    drive(1, 0, 0, 25, 9, 0);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_depth", depth, 0);
    check_eq("arst_jmp", jmp, 0);
    check_eq("arst_ret", ret, 0);
    check_eq("arst_fault", fault, 0);
    check_eq("arst_jmp_addr", jmp_addr, 0);
    tick;
    check_eq("arst_hold_depth", depth, 0);
    @(negedge clk); rst = 1'b0; call = 0;

    // branch beats rtn on an empty stack
    drive(0, 1, 1, 14, 2, 0);
    check_eq("br_rtn_jmp", jmp, 1);
    check_eq("br_rtn_ret", ret, 0);
    tick;
    check_eq("br_rtn_depth", depth, 0);

`ifndef CALL_CTRL_GUARD_EN
    drive(0, 0, 1, 0, 3, 0);
    check_eq("unf_ret", ret, 1);
    check_eq("unf_ret_addr", ret_addr, 0);
    tick;
    check_eq("unf_depth", depth, 0);
    check_eq("unf_fault", fault, 0);

    for (int i = 1; i <= 5; i++) begin
      drive(1, 0, 0, 30, 5'(i), 0);
      check_eq("ovf_jmp", jmp, 1);
      tick;
    end
    check_eq("ovf_depth", depth, 4);
    check_eq("ovf_top", ret_addr, 6);
    check_eq("ovf_fault", fault, 0);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 1, 0, 0, 0);
      check_eq("ovf_ret", ret, 1);
      check_eq("ovf_ret_addr", ret_addr, 32'(6 - i));
      tick;
      check_eq("ovf_pop_depth", depth, 32'(3 - i));
    end
`else
    for (int i = 1; i <= 4; i++) begin
      drive(1, 0, 0, 30, 5'(i), 0);
      tick;
    end
    check_eq("g_full_depth", depth, 4);
    drive(1, 0, 0, 30, 5, 0);
    check_eq("g_ovf_jmp_suppr", jmp, 0);
    tick;
    check_eq("g_ovf_fault", fault, 1);
    check_eq("g_ovf_jmp", jmp, 1);
    check_eq("g_ovf_jmp_addr", jmp_addr, 0);
    check_eq("g_ovf_depth", depth, 4);
    check_eq("g_ovf_top", ret_addr, 5);
    drive(1, 1, 1, 11, 6, 0);
    check_eq("g_flt_jmp_addr", jmp_addr, 0);
    check_eq("g_flt_ret", ret, 0);
    tick;
    check_eq("g_flt_depth", depth, 4);
    drive(0, 0, 0, 0, 0, 1);
    tick;
    check_eq("g_clr_fault", fault, 0);
    check_eq("g_clr_depth", depth, 0);
    drive(0, 0, 1, 0, 0, 0);
    check_eq("g_unf_ret", ret, 0);
    tick;
    check_eq("g_unf_fault", fault, 1);
    drive(0, 0, 0, 0, 0, 1);
    tick;
    check_eq("g_unf_clr", fault, 0);
`endif

    drive(0, 0, 0, 0, 0, 1);
    tick;
    check_eq("clr_in_run_fault", fault, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
